// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v/frame counters, sync/blank decode, strobes.
// Latency: hsync/vsync/video_on lag pixel_x/pixel_y by DELAY pixel ticks plus 1 clk; strobes are combinational.
// Backpressure: none; en low freezes divider, counters and delay line, forces strobes low, sync outputs hold.
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int CLK_DIV   = 2,
   parameter int DELAY     = 0,
   parameter int CNT_W     = 10,
   parameter int FRAME_W   = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   output logic               p_tick,
   output logic [CNT_W-1:0]   pixel_x,
   output logic [CNT_W-1:0]   pixel_y,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int CW1     = CNT_W + 1;
   localparam int DLY_N   = (DELAY > 0) ? DELAY : 1;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   // Decode bounds carry one spare bit so a bound equal to 2^CNT_W still compares correctly.
   localparam logic [CW1-1:0] H_VIS  = CW1'(H_DISPLAY);
   localparam logic [CW1-1:0] V_VIS  = CW1'(V_DISPLAY);
   localparam logic [CW1-1:0] HS_BEG = CW1'(H_DISPLAY + H_FRONT);
   localparam logic [CW1-1:0] HS_END = CW1'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CW1-1:0] VS_BEG = CW1'(V_DISPLAY + V_FRONT);
   localparam logic [CW1-1:0] VS_END = CW1'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [3:0]     DIV_LAST = 4'(CLK_DIV - 1);

   // Unsupported parameter combinations stop elaboration.
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be in 1..16");
   end
   if (DELAY < 0 || DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: DELAY must be in 0..7");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CNT_W");
   end

   logic [3:0]         r_div;
   logic [CNT_W-1:0]   r_x;
   logic [CNT_W-1:0]   r_y;
   logic [FRAME_W-1:0] r_frame;
   logic               r_hs;
   logic               r_vs;
   logic               r_vo;

   logic               w_tick;
   logic               w_x_last;
   logic               w_y_last;
   logic [CW1-1:0]     w_x_ext;
   logic [CW1-1:0]     w_y_ext;
   logic [2:0]         w_raw;
   logic [2:0]         w_dly;

   assign w_tick   = en && (r_div == DIV_LAST);
   assign w_x_last = (r_x == H_LAST);
   assign w_y_last = (r_y == V_LAST);
   assign w_x_ext  = {1'b0, r_x};
   assign w_y_ext  = {1'b0, r_y};

   // Raw {hs, vs, vo} active conditions decoded from the current counts.
   assign w_raw[2] = (w_x_ext >= HS_BEG) && (w_x_ext < HS_END);
   assign w_raw[1] = (w_y_ext >= VS_BEG) && (w_y_ext < VS_END);
   assign w_raw[0] = (w_x_ext < H_VIS) && (w_y_ext < V_VIS);

   // Pixel divider: counts enabled clks, wrapping at CLK_DIV-1 where the tick fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= 4'd0;
      end else if (en) begin
         r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
      end
   end

   // Raster counters: x every tick, y on end of line, frame count on end of frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_frame <= '0;
      end else if (w_tick) begin
         if (w_x_last) begin
            r_x <= '0;
            if (w_y_last) begin
               r_y     <= '0;
               r_frame <= r_frame + FRAME_W'(1);
            end else begin
               r_y <= r_y + CNT_W'(1);
            end
         end else begin
            r_x <= r_x + CNT_W'(1);
         end
      end
   end

   if (DELAY == 0) begin : g_no_dly
      assign w_dly = w_raw;
   end else begin : g_dly
      logic [3*DLY_N-1:0] r_pipe;
      // Shift the raw decode through DELAY stages, one step per pixel tick; newest stage at the LSBs.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_pipe <= '0;
         end else if (w_tick) begin
            r_pipe <= (r_pipe << 3) | (3*DLY_N)'(w_raw);
         end
      end
      assign w_dly = r_pipe[3*DLY_N-1 -: 3];
   end

   // Output register: apply sync polarity and retime every clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_vo <= 1'b0;
      end else begin
         r_hs <= w_dly[2] ~^ HS_POL;
         r_vs <= w_dly[1] ~^ VS_POL;
         r_vo <= w_dly[0];
      end
   end

   assign p_tick      = w_tick;
   assign pixel_x     = r_x;
   assign pixel_y     = r_y;
   assign frame_count = r_frame;
   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign video_on    = r_vo;
   assign line_start  = w_tick && (r_x == '0);
   assign frame_start = w_tick && (r_x == '0) && (r_y == '0);

endmodule
